seq_det_rr_scheduler: RTL and testbench

Time-multiplexed 1011 sequence detector shared between NCH serial requesters. A round-robin arbiter grants at most one channel per clock edge. The granted channel's saved detector context is advanced by its input bit. Per-channel non-overlapping 1011 matches are reported as a tagged pulse and accumulated in saturating counters readable by the host. The block sits between the serial front-end channels and the status/host logic, replacing NCH private detector instances with one shared next-state datapath.

---
 rtl/seq_det_rr_scheduler.sv | 158 +++++++++++++++
 tb/tb_seq_det_rr_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_rr_scheduler.sv
// seq_det_rr_scheduler
// One shared 1011 sequence detector serving NCH serial requesters.
// A round-robin arbiter picks at most one requesting channel per falling
// clock edge. That channel's saved detector state advances by its input bit.
// Non-overlapping 1011 matches are reported as a tagged one-cycle pulse and
// counted in per-channel saturating counters.
//
// Ports:
//   clk      : clock, all state updates on the falling edge
//   rst      : synchronous reset, active-low
//   req      : req[i]=1 -> channel i presents a valid bit on din[i]
//   din      : serial data bit per channel
//   ack      : one-hot grant (combinational); bit consumed at next falling edge
//   match    : registered one-cycle pulse, a channel completed 1011
//   match_ch : channel index of the latest match (held while match=0)
//   cnt_clr  : per-channel counter clear, takes effect at the next edge
//   cnt_sel  : counter readback select
//   cnt_rd   : combinational readback of counter cnt_sel
module seq_det_rr_scheduler #(
  parameter int NCH  = 4,
  parameter int CNTW = 8,
  parameter int CHW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  din,
  output logic [NCH-1:0]  ack,
  output logic            match,
  output logic [CHW-1:0]  match_ch,
  input  logic [NCH-1:0]  cnt_clr,
  input  logic [CHW-1:0]  cnt_sel,
  output logic [CNTW-1:0] cnt_rd
);

  localparam logic [2:0] ST_A = 3'b000;
  localparam logic [2:0] ST_B = 3'b001;
  localparam logic [2:0] ST_C = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;
  localparam logic [2:0] ST_E = 3'b100;

  // Detector next-state function. E behaves like A so matches never overlap;
  // the unused encodings recover to A.
  function automatic logic [2:0] next_state(input logic [2:0] s, input logic b);
    logic [2:0] n;
    n = ST_A;
    case (s)
      ST_A:    n = b ? ST_B : ST_A;
      ST_B:    n = b ? ST_B : ST_C;
      ST_C:    n = b ? ST_D : ST_A;
      ST_D:    n = b ? ST_E : ST_C;
      ST_E:    n = b ? ST_B : ST_A;
      default: n = ST_A;
    endcase
    return n;
  endfunction

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  logic [CHW-1:0]  ptr_q, ptr_d;
  logic [2:0]      state_q [NCH];
  logic [2:0]      state_d [NCH];
  logic [CNTW-1:0] cnt_q   [NCH];
  logic [CNTW-1:0] cnt_d   [NCH];
  logic            match_q, match_d;
  logic [CHW-1:0]  match_ch_q, match_ch_d;

  logic            gnt_vld;
  logic [CHW-1:0]  gnt_idx;
  logic [NCH-1:0]  ack_c;

  // ---- Arbitration: scan from ptr, wrapping, first requester wins ----
  always_comb begin
    int          idx_i;
    logic [CHW-1:0] idx_c;
    idx_i   = 0;
    idx_c   = '0;
    ack_c   = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        idx_i = (int'(ptr_q) + k) % NCH;
        idx_c = CHW'(idx_i);
        if (!gnt_vld && req[idx_c]) begin
          gnt_vld      = 1'b1;
          gnt_idx      = idx_c;
          ack_c[idx_c] = 1'b1;
        end
      end
    end
  end

  assign ack = ack_c;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
    end
  end

  // ---- Shared detector datapath and counter update ----
  always_comb begin
    match_d    = 1'b0;
    match_ch_d = match_ch_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    if (gnt_vld) begin
      state_d[gnt_idx] = next_state(state_q[gnt_idx], din[gnt_idx]);
      if (state_d[gnt_idx] == ST_E) begin
        match_d        = 1'b1;
        match_ch_d     = gnt_idx;
        cnt_d[gnt_idx] = sat_inc(cnt_q[gnt_idx]);
      end
    end
    // A clear overrides a coincident increment.
    for (int i = 0; i < NCH; i++) begin
      if (cnt_clr[i]) cnt_d[i] = '0;
    end
  end

  // ---- Register stage (falling edge) ----
  always_ff @(negedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      match_q    <= 1'b0;
      match_ch_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_A;
        cnt_q[i]   <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      match_q    <= match_d;
      match_ch_q <= match_ch_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign match    = match_q;
  assign match_ch = match_ch_q;

  // ---- Counter readback ----
  always_comb begin
    cnt_rd = '0;
    if (int'(cnt_sel) < NCH) cnt_rd = cnt_q[cnt_sel];
  end

endmodule

// File: tb/tb_seq_det_rr_scheduler.sv
module tb_seq_det_rr_scheduler;
  localparam int NCH  = 4;
  localparam int CNTW = 2;
  localparam int CHW  = 2;
  localparam int MAXC = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  din;
  logic [NCH-1:0]  ack;
  logic            match;
  logic [CHW-1:0]  match_ch;
  logic [NCH-1:0]  cnt_clr;
  logic [CHW-1:0]  cnt_sel;
  logic [CNTW-1:0] cnt_rd;

  seq_det_rr_scheduler #(.NCH(NCH), .CNTW(CNTW), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack),
    .match(match), .match_ch(match_ch), .cnt_clr(cnt_clr),
    .cnt_sel(cnt_sel), .cnt_rd(cnt_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: round-robin pointer, per-channel bits since last
  // match/reset, per-channel saturating counts.
  int   mptr;
  int   hist [NCH];
  int   hlen [NCH];
  int   mcnt [NCH];
  logic exp_match;
  int   exp_mch;
  int   last_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One falling edge with the currently driven inputs.
  task automatic cycle();
    int g;
    int idx;
    logic [NCH-1:0] eack;
    bit hit;
    g = -1;
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (mptr + k) % NCH;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    eack = '0;
    if (g >= 0) eack[g] = 1'b1;
    #1 check("ack", ack, eack);
    hit = 0;
    if (!rst) begin
      mptr = 0; exp_match = 0; exp_mch = 0;
      for (int i = 0; i < NCH; i++) begin hist[i] = 0; hlen[i] = 0; mcnt[i] = 0; end
    end else begin
      if (g >= 0) begin
        hist[g] = ((hist[g] << 1) | int'(din[g])) & 15;
        hlen[g]++;
        if (hlen[g] >= 4 && hist[g] == 11) begin
          hit = 1; hist[g] = 0; hlen[g] = 0;
        end
        mptr = (g + 1) % NCH;
      end
      exp_match = hit;
      if (hit) exp_mch = g;
      for (int i = 0; i < NCH; i++) begin
        if (cnt_clr[i]) mcnt[i] = 0;
        else if (hit && g == i && mcnt[i] < MAXC) mcnt[i]++;
      end
    end
    last_g = g;
    @(negedge clk);
    #1;
    check("match", match, exp_match);
    check("match_ch", match_ch, exp_mch);
    for (int s = 0; s < NCH; s++) begin
      cnt_sel = CHW'(s);
      #1 check($sformatf("cnt%0d", s), cnt_rd, mcnt[s]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; cnt_clr = '0;
    cycle();
    rst = 1'b1;
  endtask

  task automatic feed(input int ch, input logic b);
    int n;
    n = 0;
    req = '0; req[ch] = 1'b1; din[ch] = b;
    do begin
      cycle();
      n++;
    end while (last_g != ch && n < 2 * NCH);
    check("feed_grant", last_g, ch);
    req = '0;
  endtask

  task automatic feed1011(input int ch);
    feed(ch, 1'b1); feed(ch, 1'b0); feed(ch, 1'b1); feed(ch, 1'b1);
  endtask

  initial begin
    int   strm [NCH];
    int   bidx [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] pbit;

    rst = 1'b0; req = '1; din = '1; cnt_clr = '0; cnt_sel = '0;
    mptr = 0; exp_match = 0; exp_mch = 0; last_g = -1;
    for (int i = 0; i < NCH; i++) begin hist[i] = 0; hlen[i] = 0; mcnt[i] = 0; end

    // Reset held for two edges with all channels requesting.
    cycle();
    cycle();
    check("rst_ack", ack, 0);
    rst = 1'b1;
    cycle();
    check("rel_first_grant", last_g, 0);

    // Single channel with non-overlap.
    do_reset();
    feed1011(0);
    check("single_m1", match, 1);
    check("single_m1_ch", match_ch, 0);
    feed(0, 1'b0); feed(0, 1'b1); feed(0, 1'b1);
    check("single_no_overlap", match, 0);
    feed1011(0);
    check("single_m2", match, 1);
    cnt_sel = 0;
    #1 check("single_cnt", cnt_rd, 2);

    // Interleaved streams, all channels requesting.
    do_reset();
    strm[0] = 4'b1011; strm[1] = 4'b1011; strm[2] = 4'b0000; strm[3] = 4'b1010;
    for (int i = 0; i < NCH; i++) bidx[i] = 0;
    req = '1;
    for (int e = 0; e < 16; e++) begin
      for (int c = 0; c < NCH; c++) din[c] = 1'((strm[c] >> (3 - (bidx[c] % 4))) & 1);
      cycle();
      check("ilv_order", last_g, e % NCH);
      if (last_g >= 0) bidx[last_g]++;
      if (e == 12) check("ilv_m_ch0", {match, 2'(match_ch)}, 3'b100);
      if (e == 13) check("ilv_m_ch1", {match, 2'(match_ch)}, 3'b101);
    end
    req = '0;

    // Fairness: channels 0 and 2 alternate.
    do_reset();
    req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      din = 4'($urandom);
      cycle();
      check("fair_alt", last_g, (k % 2 == 0) ? 0 : 2);
    end
    req = '0;

    // Saturation and clear-wins.
    do_reset();
    for (int m = 1; m <= 5; m++) begin
      feed1011(0);
      if (m == 3 || m == 5) begin
        cnt_sel = 0;
        #1 check("sat_cnt", cnt_rd, 3);
      end
    end
    feed(0, 1'b1); feed(0, 1'b0); feed(0, 1'b1);
    cnt_clr = 4'b0001;
    feed(0, 1'b1);
    cnt_clr = '0;
    check("clr_win_match", match, 1);
    cnt_sel = 0;
    #1 check("clr_win_cnt", cnt_rd, 0);

    // Reset mid-pattern discards partial progress.
    do_reset();
    feed(0, 1'b1); feed(0, 1'b0); feed(0, 1'b1);
    rst = 1'b0; req = 4'b0001; din = 4'b0001;
    cycle();
    rst = 1'b1;
    feed(0, 1'b1);
    check("midrst_no_match", match, 0);
    feed(0, 1'b0); feed(0, 1'b1);
    check("midrst_no_match2", match, 0);
    feed(0, 1'b1);

    // Randomized requesters with handshake, clears and occasional reset.
    do_reset();
    pend = '0; pbit = '0;
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && $urandom_range(1, 0) == 1) begin
          pend[c] = 1'b1;
          pbit[c] = ($urandom_range(3, 0) != 0);
        end
      end
      req = pend;
      din = pbit;
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c]) din[c] = 1'($urandom);
        cnt_clr[c] = ($urandom_range(15, 0) == 0);
      end
      rst = ($urandom_range(99, 0) != 0);
      cycle();
      if (last_g >= 0) pend[last_g] = 1'b0;
    end
    rst = 1'b1; cnt_clr = '0; req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
